mult16_part_sched: RTL and testbench
====================================

MULT16_PART_SCHED -- requirements
Module: mult16_part_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one 6-in/4-out approximate partition unit (PU); fixed at 4 for this block.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  4  per-requester operand valid.
REQ-005 req_data  input  24  requester i operand in bits [6i+5:6i] (pi0..pi5 order, pi0 = LSB).
REQ-006 req_ready  output  4  one-hot or zero grant; a transfer for requester i occurs when req_valid[i] && req_ready[i].
REQ-007 pu_in  output  6  operand driven to the shared PU (combinational PU, no internal state).
REQ-008 pu_out  input  4  PU result (po0..po3, po0 = LSB), valid in the same cycle as pu_in.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_id  output  2  index of the requester that issued the result.
REQ-011 rsp_data  output  4  PU result.
REQ-012 rsp_ready  input  1  consumer accepts the result when rsp_valid && rsp_ready.
REQ-013 flush  input  1  level request: stop granting and drain the pipeline.
REQ-014 flush_done  output  1  high while in state DONE.
REQ-015 op_count  output  16  number of completed responses, saturating.

Function
REQ-016 Pipeline has two registers: S1 (valid, id, 6-bit operand) and S2 (valid, id, 4-bit result).
REQ-017 pu_in = S1 operand when S1 valid, else 6'b0.
REQ-018 S2 loads {S1 id, pu_out} when S1 valid and (S2 empty or S2 consumed this cycle); S1 then empties unless reloaded in the same cycle.
REQ-019 S1 is free when S1 is empty or S1 advances to S2 this cycle; grant is issued only when S1 is free and the state is RUN.
REQ-020 Arbitration is round-robin: search starts at last_grant+1 mod 4; the first requester with req_valid set is granted; at most one req_ready bit is high per cycle.
REQ-021 last_grant updates only on an actual transfer; when no transfer occurs it holds.
REQ-022 req_ready is combinational from req_valid, S1/S2 state and rsp_ready; it is never asserted for a requester whose req_valid is low.
REQ-023 Latency: operand accepted at edge N appears with rsp_valid = 1 after edge N+1 when there is no back-pressure; sustained throughput is 1 result/cycle when rsp_ready = 1.
REQ-024 rsp_valid, rsp_id and rsp_data are S2 contents and hold stable while rsp_valid && !rsp_ready.
REQ-025 A full pipeline with rsp_ready = 0 stalls: S1 and S2 hold and req_ready = 0.
REQ-026 When rsp_ready is asserted with both stages full, S2 takes S1 and S1 accepts a new grant in the same cycle (no bubble).
REQ-027 op_count increments by 1 on each rsp_valid && rsp_ready and saturates at 16'hFFFF.
REQ-028 FSM states: RUN, DRAIN, DONE.
- RUN: granting is enabled; flush = 1 moves to DRAIN at the next edge, and no grant is issued in the cycle flush is first seen.
- DRAIN: no grants; moves to DONE when S1 and S2 are both empty.
- DONE: no grants; flush_done = 1; flush = 0 moves to RUN.
REQ-029 flush in RUN with an empty pipeline reaches DONE in 2 edges (RUN->DRAIN->DONE).
REQ-030 Requests pending during DRAIN/DONE are not lost: the requester holds req_valid and is served after the return to RUN, with round-robin order continuing from the preserved last_grant.

Reset
REQ-031 On rst = 1 at a rising edge, the following are cleared:
- S1 valid = 0, S2 valid = 0;
- last_grant = 3, so requester 0 has first priority;
- state = RUN;
- op_count = 0.
REQ-032 During and after reset: rsp_valid = 0, req_ready = 0 while rst = 1, pu_in = 0, flush_done = 0, rsp_id = 0, rsp_data = 0.
REQ-033 Reset mid-operation discards in-flight S1/S2 contents without producing a response.

Verification
REQ-034 After reset, req_valid = 4'b1111, rsp_ready = 1 for 8 cycles -> grants follow order 0,1,2,3,0,1,2,3; rsp_id follows the same order starting 2 cycles after the first grant; op_count = 6 at the end of cycle 8.
REQ-035 Requester 2 issues 6'b101101, PU model returns 4'b1101 -> rsp_valid at cycle N+1, rsp_id = 2, rsp_data = 4'b1101, op_count = 1.
REQ-036 rsp_ready = 0 for 5 cycles with all requesters valid -> exactly 2 operands accepted, then req_ready = 0 and rsp_data stable; raising rsp_ready resumes at 1 result/cycle with no bubble.
REQ-037 Two results in flight, then flush = 1 -> no further grants, both results delivered, flush_done = 1 one edge after S2 empties; flush = 0 -> RUN, next grant goes to last_grant+1.
REQ-038 op_count preloaded via 65535 completed transfers, then one more transfer -> op_count stays 16'hFFFF.
REQ-039 rst pulsed while S1 and S2 are full -> no response emitted, op_count = 0, first post-reset grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/mult16_part_sched_if.sv
// Request, shared-PU and response bundle for mult16_part_sched.
// slave is the scheduler side; master is the requesters/PU/consumer side.
interface mult16_part_sched_if;
  logic [3:0]  req_valid;
  logic [23:0] req_data;
  logic [3:0]  req_ready;
  logic [5:0]  pu_in;
  logic [3:0]  pu_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        rsp_ready;

  modport master (
    output req_valid, req_data, pu_out, rsp_ready,
    input  req_ready, pu_in, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, pu_out, rsp_ready,
    output req_ready, pu_in, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mult16_part_sched.sv
// Round-robin scheduler sharing one combinational 6-in/4-out partition unit
// among four requesters through a two-stage pipeline, with flush/drain control.
module mult16_part_sched #(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  mult16_part_sched_if.slave  bus,
  input  logic                flush,
  output logic                flush_done,
  output logic [15:0]         op_count
);
  localparam int IDW = 2;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic             s1_valid_reg;
  logic [IDW-1:0]   s1_id_reg;
  logic [5:0]       s1_op_reg;
  logic             s2_valid_reg;
  logic [IDW-1:0]   s2_id_reg;
  logic [3:0]       s2_res_reg;
  logic [IDW-1:0]   last_grant_reg;
  logic [15:0]      op_count_reg;

  logic [5:0]       lane [NREQ];
  logic             rsp_fire, s1_adv, s1_free, grant_en, grant_any, transfer;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane[gi] = bus.req_data[6*gi +: 6];
    end
  endgenerate

  assign rsp_fire = s2_valid_reg && bus.rsp_ready;
  assign s1_adv   = s1_valid_reg && (!s2_valid_reg || bus.rsp_ready);
  assign s1_free  = !s1_valid_reg || s1_adv;
  // No grant in the very cycle flush is first seen, nor while reset is held.
  assign grant_en = (state_reg == RUN) && !flush && s1_free && !rst;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_grant_reg + IDW'(k);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign transfer      = grant_en && grant_any;
  assign bus.req_ready = transfer ? (4'(1) << grant_idx) : 4'b0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if (!s1_valid_reg && !s2_valid_reg) state_next = DONE;
      DONE:    if (!flush) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      s1_valid_reg   <= 1'b0;
      s1_id_reg      <= '0;
      s1_op_reg      <= '0;
      s2_valid_reg   <= 1'b0;
      s2_id_reg      <= '0;
      s2_res_reg     <= '0;
      last_grant_reg <= IDW'(NREQ - 1);
      op_count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (transfer) begin
        s1_valid_reg   <= 1'b1;
        s1_id_reg      <= grant_idx;
        s1_op_reg      <= lane[grant_idx];
        last_grant_reg <= grant_idx;
      end else if (s1_adv) begin
        s1_valid_reg <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid_reg <= 1'b1;
        s2_id_reg    <= s1_id_reg;
        s2_res_reg   <= bus.pu_out;
      end else if (rsp_fire) begin
        s2_valid_reg <= 1'b0;
      end
      if (rsp_fire && (op_count_reg != 16'hFFFF))
        op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign bus.pu_in     = s1_valid_reg ? s1_op_reg : 6'b0;
  assign bus.rsp_valid = s2_valid_reg;
  assign bus.rsp_id    = s2_id_reg;
  assign bus.rsp_data  = s2_res_reg;
  assign flush_done    = (state_reg == DONE);
  assign op_count      = op_count_reg;
endmodule

// File: tb/tb_mult16_part_sched.sv
// Randomized and directed bench for mult16_part_sched against a transaction-level
// model: in-order queue of accepted operands, round-robin pointer and flush state.
module tb_mult16_part_sched;
  logic        clk;
  logic        rst;
  logic        flush;
  logic        flush_done;
  logic [15:0] op_count;

  mult16_part_sched_if bus ();

  mult16_part_sched #(.NREQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .flush      (flush),
    .flush_done (flush_done),
    .op_count   (op_count)
  );

  function automatic logic [3:0] pu_f(input logic [5:0] x);
    return x[3:0] ^ {2'b00, x[5] & x[4], x[4]};
  endfunction

  assign bus.pu_out = pu_f(bus.pu_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [5:0] data;
    int         acc;
  } item_t;

  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  item_t q[$];
  int    m_last, m_state, m_count, edge_cnt;
  int    g_seen;
  int    tests, fails;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare outputs against the model, then advance the model at the edge.
  task automatic run_cycle(input bit do_chk);
    int n;
    bit hv, fire, room, gok, gany;
    int gid;
    logic [3:0] exp_rdy;
    logic [5:0] exp_pu;
    #1;
    n    = q.size();
    hv   = (n > 0) && (q[0].acc < edge_cnt);
    fire = hv && bus.rsp_ready;
    room = (n < 2) || fire;
    gok  = !rst && (m_state == M_RUN) && !flush && room;
    gany = 0;
    gid  = 0;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last + k) % 4;
      if (!gany && bus.req_valid[c]) begin
        gany = 1;
        gid  = c;
      end
    end
    exp_rdy = (gok && gany) ? 4'(1 << gid) : 4'b0;
    if (n == 2) exp_pu = q[1].data;
    else if (n == 1 && q[0].acc == edge_cnt) exp_pu = q[0].data;
    else exp_pu = 6'b0;
    g_seen = -1;
    for (int k = 0; k < 4; k++) if (bus.req_ready[k]) g_seen = k;
    if (do_chk) begin
      check_val("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check_val("rsp_valid", 32'(bus.rsp_valid), 32'(hv));
      if (hv) begin
        check_val("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
        check_val("rsp_data", 32'(bus.rsp_data), 32'(pu_f(q[0].data)));
      end
      check_val("pu_in", 32'(bus.pu_in), 32'(exp_pu));
      check_val("flush_done", 32'(flush_done), 32'(m_state == M_DONE));
      check_val("op_count", 32'(op_count), 32'(m_count));
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_last  = 3;
      m_state = M_RUN;
      m_count = 0;
    end else begin
      case (m_state)
        M_RUN:   if (flush) m_state = M_DRAIN;
        M_DRAIN: if (n == 0) m_state = M_DONE;
        default: if (!flush) m_state = M_RUN;
      endcase
      if (fire) begin
        void'(q.pop_front());
        if (m_count < 65535) m_count++;
      end
      if (gok && gany) begin
        q.push_back('{id: 2'(gid), data: bus.req_data[6*gid +: 6], acc: edge_cnt + 1});
        m_last = gid;
      end
    end
    edge_cnt++;
    #1;
  endtask

  task automatic do_reset(input bit do_chk);
    rst = 1'b1;
    run_cycle(do_chk);
    rst = 1'b0;
  endtask

  int cnt;

  initial begin
    tests = 0; fails = 0; edge_cnt = 0;
    m_last = 3; m_state = M_RUN; m_count = 0;
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = 4'b0; bus.req_data = 24'b0; bus.rsp_ready = 1'b0;
    do_reset(1'b0);
    do_reset(1'b1);
    check_val("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check_val("rst_rsp_id", 32'(bus.rsp_id), 0);
    check_val("rst_rsp_data", 32'(bus.rsp_data), 0);
    check_val("rst_pu_in", 32'(bus.pu_in), 0);
    check_val("rst_op_count", 32'(op_count), 0);
    check_val("rst_flush_done", 32'(flush_done), 0);

    // Full load: round-robin 0,1,2,3,... and six completions after eight edges.
    bus.req_valid = 4'hF; bus.rsp_ready = 1'b1; bus.req_data = 24'($urandom);
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b1);
      check_val("rr_order", 32'(g_seen), 32'(i % 4));
    end
    check_val("op_count_8", 32'(op_count), 6);

    // Single request from requester 2.
    do_reset(1'b1);
    bus.req_valid = 4'b0100;
    bus.req_data  = {6'd0, 6'b101101, 12'd0};
    run_cycle(1'b1);
    check_val("single_grant", 32'(g_seen), 2);
    bus.req_valid = 4'b0;
    run_cycle(1'b1);
    check_val("single_valid", 32'(bus.rsp_valid), 1);
    check_val("single_id", 32'(bus.rsp_id), 2);
    check_val("single_data", 32'(bus.rsp_data), 32'(4'b1101));
    run_cycle(1'b1);
    check_val("single_count", 32'(op_count), 1);

    // Back-pressure: only two operands fit, then no-bubble resume.
    do_reset(1'b1);
    bus.req_valid = 4'hF; bus.rsp_ready = 1'b0;
    bus.req_data  = {6'd11, 6'd22, 6'd33, 6'd45};
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1);
      if (g_seen >= 0) cnt++;
    end
    check_val("stall_accepts", 32'(cnt), 2);
    check_val("stall_data", 32'(bus.rsp_data), 32'(pu_f(6'd45)));
    bus.rsp_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1);
      if (bus.rsp_valid) cnt++;
    end
    check_val("resume_no_bubble", 32'(cnt), 6);

    // Flush with two results in flight.
    do_reset(1'b1);
    bus.req_valid = 4'hF; bus.rsp_ready = 1'b0;
    run_cycle(1'b1);
    run_cycle(1'b1);
    flush = 1'b1; bus.rsp_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b1);
      if (g_seen >= 0) cnt++;
      if (flush_done) break;
    end
    check_val("flush_no_grant", 32'(cnt), 0);
    check_val("flush_done_reached", 32'(flush_done), 1);
    check_val("flush_delivered", 32'(op_count), 2);
    flush = 1'b0;
    run_cycle(1'b1);
    run_cycle(1'b1);
    check_val("post_flush_grant", 32'(g_seen), 2);

    // Reset with both stages full.
    do_reset(1'b1);
    bus.req_valid = 4'hF; bus.rsp_ready = 1'b0;
    run_cycle(1'b1);
    run_cycle(1'b1);
    do_reset(1'b1);
    bus.req_valid = 4'b1010;
    check_val("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    check_val("midrst_op_count", 32'(op_count), 0);
    check_val("midrst_pu_in", 32'(bus.pu_in), 0);
    run_cycle(1'b1);
    check_val("midrst_first_grant", 32'(g_seen), 1);

    // Randomized traffic with flush and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid = 4'($urandom);
      bus.req_data  = 24'($urandom);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) flush = !flush;
      rst = ($urandom_range(0, 299) == 0);
      run_cycle(1'b1);
    end
    rst = 1'b0; flush = 1'b0;

    // Saturation of the response counter.
    do_reset(1'b1);
    bus.req_valid = 4'hF; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 65537; i++) run_cycle(1'b0);
    check_val("sat_reach", 32'(op_count), 32'hFFFF);
    run_cycle(1'b1);
    run_cycle(1'b1);
    check_val("sat_hold", 32'(op_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
